// File: rtl/fb_arbiter.sv
// Purpose: arbitrates one single-port framebuffer RAM between display read bursts and draw-engine pixel writes.
// Latency: ack and first RAM cycle 1 clk after a request is seen in IDLE; read data returns 2 clks after each read strobe.
// Backpressure: requesters hold req until ack; display has priority, and the draw engine is forced in after MAX_WAIT waiting cycles.
//
// Ports:
//   clock, reset                    clock and synchronous active-low reset
//   disp_req/disp_addr/disp_ack     display burst request handshake
//   disp_rdata/disp_rvalid          display read return, one pulse per beat
//   draw_req/draw_addr/draw_wdata   draw write request, held until draw_ack
//   draw_ack                        write accepted (same cycle as RAM write)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   single-port RAM interface
module fb_arbiter #(
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 12,
  parameter int BURST_LEN = 16,
  parameter int MAX_WAIT  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              draw_req,
  input  logic [ADDR_W-1:0] draw_addr,
  input  logic [DATA_W-1:0] draw_wdata,
  output logic              draw_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, BURST, WRITE} state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                force_draw;

  logic                disp_ack_q, disp_ack_d;
  logic                draw_ack_q, draw_ack_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                rd_pipe_q, rd_pipe_d;
  logic                disp_rvalid_q, disp_rvalid_d;
  logic [DATA_W-1:0]   disp_rdata_q, disp_rdata_d;

  assign force_draw = (wait_cnt_q == WAIT_MAX);

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, including the burst beat counter and captured base address
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    base_d  = base_q;
    case (state_q)
      IDLE: begin
        if (force_draw && draw_req) begin
          state_d = WRITE;
        end else if (disp_req) begin
          state_d = BURST;
          base_d  = disp_addr;
          beat_d  = '0;
        end else if (draw_req) begin
          state_d = WRITE;
        end
      end
      BURST: begin
        if (beat_q == LAST_BEAT) begin
          state_d = IDLE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: computed from the next state so the registered outputs
  // line up with the state they belong to.
  always_comb begin
    disp_ack_d  = (state_q == IDLE) && (state_d == BURST);
    draw_ack_d  = (state_d == WRITE);
    mem_en_d    = (state_d != IDLE);
    mem_we_d    = (state_d == WRITE);
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (state_d == BURST) begin
      // Natural truncation gives the modulo-2^ADDR_W wrap.
      mem_addr_d = base_d + ADDR_W'(beat_d);
    end else if (state_d == WRITE) begin
      mem_addr_d  = draw_addr;
      mem_wdata_d = draw_wdata;
    end
  end

  // Starvation counter and read-return pipeline
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (draw_ack_q) begin
      wait_cnt_d = '0;
    end else if (draw_req && (wait_cnt_q != WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    // Stage 1 marks the RAM cycle, stage 2 is the output register.
    rd_pipe_d     = mem_en_q && !mem_we_q;
    disp_rvalid_d = rd_pipe_q;
    disp_rdata_d  = rd_pipe_q ? mem_rdata : disp_rdata_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      beat_q        <= '0;
      base_q        <= '0;
      wait_cnt_q    <= '0;
      disp_ack_q    <= 1'b0;
      draw_ack_q    <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rd_pipe_q     <= 1'b0;
      disp_rvalid_q <= 1'b0;
      disp_rdata_q  <= '0;
    end else begin
      beat_q        <= beat_d;
      base_q        <= base_d;
      wait_cnt_q    <= wait_cnt_d;
      disp_ack_q    <= disp_ack_d;
      draw_ack_q    <= draw_ack_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rd_pipe_q     <= rd_pipe_d;
      disp_rvalid_q <= disp_rvalid_d;
      disp_rdata_q  <= disp_rdata_d;
    end
  end

  assign disp_ack    = disp_ack_q;
  assign draw_ack    = draw_ack_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign disp_rvalid = disp_rvalid_q;
  assign disp_rdata  = disp_rdata_q;

endmodule
